// File: rtl/timed_onehot_decoder.sv
// Registered binary-to-one-hot decoder with a hold timer.
// Each accepted code drives y for HOLD cycles, followed by GAP idle cycles.
module timed_onehot_decoder #(
  parameter int N    = 2,
  parameter int HOLD = 4,
  parameter int GAP  = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic           in_valid,
  input  logic [N-1:0]   in_code,
  output logic           in_ready,
  output logic [2**N-1:0] y,
  output logic [N-1:0]   out_code,
  output logic           busy,
  output logic           done
);

  localparam int W  = 2**N;
  localparam int MX = (HOLD > GAP) ? HOLD : GAP;
  localparam int CW = $clog2((MX < 1) ? 1 : MX) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_GAP
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  y_q, y_d;
  logic [N-1:0]  code_q, code_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      y_q     <= '0;
      code_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign in_ready = (state_q == S_IDLE) && en;

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          y_d     = W'(1) << in_code;
          code_d  = in_code;
          cnt_d   = CW'(HOLD - 1);
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (!en) begin
          y_d     = '0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          y_d    = '0;
          done_d = 1'b1;
          if (GAP > 0) begin
            cnt_d   = CW'(GAP - 1);
            state_d = S_GAP;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_GAP: begin
        if (!en) begin
          y_d     = '0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        y_d     = '0;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign y        = y_q;
  assign out_code = code_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;

endmodule

// File: tb/tb_timed_onehot_decoder.sv
// Directed bench for timed_onehot_decoder.
// Main instance uses HOLD=4/GAP=1; a second instance covers GAP=0.
module tb_timed_onehot_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, in_valid;
  logic [1:0] in_code;
  logic       in_ready, busy, done;
  logic [3:0] y;
  logic [1:0] out_code;

  logic       en_b, in_valid_b;
  logic [1:0] in_code_b;
  logic       in_ready_b, busy_b, done_b;
  logic [3:0] y_b;
  logic [1:0] out_code_b;

  int checks = 0;
  int errors = 0;
  int n;

  always #5 clk = ~clk;

  timed_onehot_decoder #(.N(2), .HOLD(4), .GAP(1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .in_valid(in_valid), .in_code(in_code),
    .in_ready(in_ready), .y(y), .out_code(out_code),
    .busy(busy), .done(done)
  );

  timed_onehot_decoder #(.N(2), .HOLD(4), .GAP(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en_b),
    .in_valid(in_valid_b), .in_code(in_code_b),
    .in_ready(in_ready_b), .y(y_b), .out_code(out_code_b),
    .busy(busy_b), .done(done_b)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; in_valid = 1'b0; in_code = 2'd0;
    en_b = 1'b1; in_valid_b = 1'b0; in_code_b = 2'd0;
    #1;
    check("rst_y", y, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_code", out_code, 0);
    check("rst_ready", in_ready, 1);
    step(); step();
    rst_n = 1'b1;
    step();

    // async reset in the middle of a hold
    in_code = 2'd1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    check("pre_rst_y", y, 4'b0010);
    #2 rst_n = 1'b0;
    #1;
    check("arst_y", y, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_ready", in_ready, 1);

    // single accept of code 2
    in_code = 2'd2; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("t2_y0", y, 4'b0100);
    check("t2_code", out_code, 2);
    check("t2_busy", busy, 1);
    check("t2_ready0", in_ready, 0);
    for (int i = 1; i < 4; i++) begin
      step();
      check("t2_yhold", y, 4'b0100);
      check("t2_nodone", done, 0);
    end
    step();
    check("t2_ydrop", y, 0);
    check("t2_done", done, 1);
    check("t2_gapbusy", busy, 1);
    check("t2_gapready", in_ready, 0);
    step();
    check("t2_done_clr", done, 0);
    check("t2_idle", busy, 0);
    check("t2_ready", in_ready, 1);

    // back-to-back sweep with in_valid held high
    in_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      in_code = 2'(c);
      check("t3_ready", in_ready, 1);
      step();
      check("t3_y", y, 32'd1 << c);
      check("t3_code", out_code, c);
      n = 1;
      while (!in_ready && n < 20) begin
        step();
        n++;
      end
      check("t3_spacing", n, 6);
    end
    in_valid = 1'b0;

    // abort on the second hold cycle
    in_code = 2'd1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    check("t4_y", y, 4'b0010);
    en = 1'b0;
    #1;
    check("t4_ready_en0", in_ready, 0);
    step();
    check("t4_abort_y", y, 0);
    check("t4_abort_done", done, 0);
    check("t4_abort_busy", busy, 0);
    check("t4_ready_blk", in_ready, 0);
    in_code = 2'd2; in_valid = 1'b1;
    step();
    check("t4_no_accept", y, 0);
    check("t4_no_done", done, 0);
    in_valid = 1'b0;
    en = 1'b1;
    #1;
    check("t4_ready_back", in_ready, 1);
    in_code = 2'd3; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("t4_new_y", y, 4'b1000);
    check("t4_new_code", out_code, 3);
    repeat (4) step();
    check("t4_done", done, 1);
    step();
    check("t4_idle", in_ready, 1);

    // in_valid during hold is ignored
    in_code = 2'd1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    in_code = 2'd3; in_valid = 1'b1;
    check("t5_ready0", in_ready, 0);
    step();
    in_valid = 1'b0;
    check("t5_y", y, 4'b0010);
    check("t5_code", out_code, 1);
    step();
    check("t5_y2", y, 4'b0010);
    check("t5_done", done, 1'b0);
    step();
    check("t5_done_end", done, 1);
    check("t5_y_end", y, 0);
    step();
    check("t5_ready", in_ready, 1);
    check("t5_no_requeue", busy, 0);

    // GAP=0 instance
    in_code_b = 2'd3; in_valid_b = 1'b1;
    check("t6_ready", in_ready_b, 1);
    step();
    check("t6_y", y_b, 4'b1000);
    n = 1;
    while (!in_ready_b && n < 20) begin
      check("t6_onehot0", $onehot0(y_b), 1);
      step();
      n++;
    end
    check("t6_spacing", n, 5);
    check("t6_done", done_b, 1);
    check("t6_ydrop", y_b, 0);
    in_code_b = 2'd0;
    step();
    in_valid_b = 1'b0;
    check("t6_y2", y_b, 4'b0001);
    check("t6_code2", out_code_b, 0);
    check("t6_done_clr", done_b, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
